// File: rtl/traffic_light_pkg.sv
// Shared types, opcodes, lamp encodings and default durations
// for the traffic light sequencer.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam logic [2:0] OP_NSG   = 3'b000;
    localparam logic [2:0] OP_EWG   = 3'b001;
    localparam logic [2:0] OP_YEL   = 3'b010;
    localparam logic [2:0] OP_ARD   = 3'b011;
    localparam logic [2:0] OP_FLON  = 3'b100;
    localparam logic [2:0] OP_FLOFF = 3'b101;
    localparam logic [2:0] OP_PED   = 3'b110;
    localparam logic [2:0] OP_BAD   = 3'b111;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    localparam logic [4:0] DEF_NS_GREEN = 5'd10;
    localparam logic [4:0] DEF_EW_GREEN = 5'd10;
    localparam logic [4:0] DEF_YELLOW   = 5'd3;
    localparam logic [4:0] DEF_ALLRED   = 5'd2;

    function automatic state_t seq_next(input state_t st);
        state_t nx;
        case (st)
            ALLRED_A:  nx = NS_GREEN;
            NS_GREEN:  nx = NS_YELLOW;
            NS_YELLOW: nx = ALLRED_B;
            ALLRED_B:  nx = EW_GREEN;
            EW_GREEN:  nx = EW_YELLOW;
            default:   nx = ALLRED_A;
        endcase
        return nx;
    endfunction

    function automatic logic [2:0] ns_lamp(input state_t st, input logic flash_on);
        logic [2:0] l;
        case (st)
            NS_GREEN:  l = L_GRN;
            NS_YELLOW: l = L_YEL;
            FLASH:     l = flash_on ? L_YEL : L_OFF;
            default:   l = L_RED;
        endcase
        return l;
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t st, input logic flash_on);
        logic [2:0] l;
        case (st)
            EW_GREEN:  l = L_GRN;
            EW_YELLOW: l = L_YEL;
            FLASH:     l = flash_on ? L_YEL : L_OFF;
            default:   l = L_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_sequencer_prescaler.sv
// Phase tick generator: one-cycle tick every TICK_CYCLES clocks,
// realigned to zero whenever the sequencer enters a new state.
module tick_prescaler #(
    parameter int TICK_CYCLES = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_sequencer.sv
// NS/EW phase sequencer configured by UART command bytes:
// command decoder, duration registers, phase FSM and phase counter.
module traffic_light_sequencer #(
    parameter int CLK_HZ      = 12_000_000,
    parameter int TICK_CYCLES = 12_000_000,
    parameter int PED_MIN     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase,
    output logic       cmd_ack,
    output logic       led_error
);

    import traffic_light_pkg::*;

    localparam logic [4:0] PED_REM = 5'(PED_MIN);

    // CLK_HZ only documents the clock the tick rate was chosen for.
    if (CLK_HZ < TICK_CYCLES) begin : g_subsecond_tick
    end

    logic [2:0] opcode;
    logic [4:0] value;
    logic       cmd_valid;
    logic       is_dur;
    logic       rejected;
    logic       accepted;

    state_t     state_q;
    state_t     state_d;
    state_t     seq_state;
    logic [4:0] rem_q;
    logic [4:0] rem_d;
    logic [4:0] seq_dur;
    logic       flash_on_q;
    logic       flash_on_d;
    logic       tick;
    logic       restart;
    logic       ped_hit;
    logic       in_green;

    logic [4:0] ns_green_q;
    logic [4:0] ew_green_q;
    logic [4:0] yellow_q;
    logic [4:0] allred_q;

    assign opcode    = rx_data[7:5];
    assign value     = rx_data[4:0];
    assign cmd_valid = rx_valid & ~rx_error;

    assign is_dur = (opcode == OP_NSG) | (opcode == OP_EWG) |
                    (opcode == OP_YEL) | (opcode == OP_ARD);

    assign rejected = cmd_valid & ((opcode == OP_BAD) |
                                   (is_dur & (value == 5'd0)));
    assign accepted = cmd_valid & ~rejected;

    assign in_green = (state_q == NS_GREEN) | (state_q == EW_GREEN);
    assign ped_hit  = accepted & (opcode == OP_PED) & in_green &
                      (rem_q > PED_REM);

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    assign seq_state = seq_next(state_q);

    always_comb begin
        seq_dur = allred_q;
        case (seq_state)
            NS_GREEN:             seq_dur = ns_green_q;
            EW_GREEN:             seq_dur = ew_green_q;
            NS_YELLOW, EW_YELLOW: seq_dur = yellow_q;
            default:              seq_dur = allred_q;
        endcase
    end

    // Commands override the timed sequence; FLASH beats a same-cycle transition.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        flash_on_d = flash_on_q;

        if (state_q == FLASH) begin
            if (tick) begin
                flash_on_d = ~flash_on_q;
            end
        end else if (tick) begin
            if (rem_q <= 5'd1) begin
                state_d = seq_state;
                rem_d   = seq_dur;
            end else begin
                rem_d = rem_q - 5'd1;
            end
        end

        if (ped_hit) begin
            rem_d = PED_REM;
        end

        if (accepted && opcode == OP_FLON && state_q != FLASH) begin
            state_d    = FLASH;
            flash_on_d = 1'b1;
        end else if (accepted && opcode == OP_FLOFF && state_q == FLASH) begin
            state_d    = ALLRED_A;
            rem_d      = allred_q;
            flash_on_d = 1'b0;
        end
    end

    assign restart = (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALLRED_A;
            rem_q      <= DEF_ALLRED;
            flash_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            flash_on_q <= flash_on_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ns_green_q <= DEF_NS_GREEN;
            ew_green_q <= DEF_EW_GREEN;
            yellow_q   <= DEF_YELLOW;
            allred_q   <= DEF_ALLRED;
        end else if (accepted) begin
            case (opcode)
                OP_NSG:  ns_green_q <= value;
                OP_EWG:  ew_green_q <= value;
                OP_YEL:  yellow_q   <= value;
                OP_ARD:  allred_q   <= value;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ack   <= 1'b0;
            led_error <= 1'b0;
        end else begin
            cmd_ack <= accepted;
            if (rx_error || rejected) begin
                led_error <= 1'b1;
            end else if (accepted && opcode == OP_FLOFF) begin
                led_error <= 1'b0;
            end
        end
    end

    // Lamps are decoded from the next state so they flip with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= 3'(ALLRED_A);
            ns_light <= L_RED;
            ew_light <= L_RED;
        end else begin
            phase    <= 3'(state_d);
            ns_light <= ns_lamp(state_d, flash_on_d);
            ew_light <= ew_lamp(state_d, flash_on_d);
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench for traffic_light_sequencer: expected phase changes
// go into a scoreboard queue and are matched against observed changes.
module tb_traffic_light_sequencer;

    localparam int TICK = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [2:0] phase;
    logic       cmd_ack;
    logic       led_error;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] ph;
        int         at;
    } ev_t;

    ev_t        sb[$];
    ev_t        ev;
    logic [2:0] last_phase = 3'd0;

    traffic_light_sequencer #(
        .CLK_HZ     (12_000_000),
        .TICK_CYCLES(TICK),
        .PED_MIN    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .phase    (phase),
        .cmd_ack  (cmd_ack),
        .led_error(led_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b100_100;
            3'd1:    return 6'b001_100;
            3'd2:    return 6'b010_100;
            3'd3:    return 6'b100_100;
            3'd4:    return 6'b100_001;
            3'd5:    return 6'b100_010;
            default: return 6'b000_000;
        endcase
    endfunction

    // Scoreboard consumer: every observed phase change pops one expectation.
    always @(negedge clk) begin
        if (rst) begin
            last_phase = phase;
        end else if (phase !== last_phase) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_phase: got phase %0d at cycle %0d, none expected",
                         phase, cyc);
            end else begin
                ev = sb.pop_front();
                if (phase !== ev.ph || cyc != ev.at) begin
                    mismatched++;
                    $display("FAIL phase_change: got phase %0d at cycle %0d, expected phase %0d at cycle %0d",
                             phase, cyc, ev.ph, ev.at);
                end
                if (ev.ph != 3'd6) begin
                    compared++;
                    if ({ns_light, ew_light} !== exp_lamps(ev.ph)) begin
                        mismatched++;
                        $display("FAIL lamps_ph%0d: got ns=%b ew=%b, expected %b",
                                 ev.ph, ns_light, ew_light, exp_lamps(ev.ph));
                    end
                end
            end
            last_phase = phase;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_ev(input logic [2:0] ph, input int at);
        sb.push_back('{ph, at});
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = err;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic check_drained(input string name);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drained: %0d phase changes still pending, expected 0",
                     name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset(output int r);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if (ns_light !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_ns: got %b, expected 100", ns_light);
        end
        compared++;
        if (ew_light !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_ew: got %b, expected 100", ew_light);
        end
        compared++;
        if (phase !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_phase: got %0d, expected 0", phase);
        end
        compared++;
        if (cmd_ack !== 1'b0 || led_error !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got ack=%b err=%b, expected 0 0",
                     cmd_ack, led_error);
        end
        rst = 1'b0;
        r = cyc;
    endtask

    task automatic test_normal_cycle(input int r);
        push_ev(3'd1, r + 20);
        push_ev(3'd2, r + 120);
        push_ev(3'd3, r + 150);
        push_ev(3'd4, r + 170);
        push_ev(3'd5, r + 270);
        push_ev(3'd0, r + 300);
        wait_until(r + 301);
        check_drained("normal");
    endtask

    task automatic test_duration_write(input int e, output int n);
        push_ev(3'd1, e);
        wait_until(e + 5);
        send(8'h05, 1'b0);
        compared++;
        if (cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL dur_ack: got %b, expected 1", cmd_ack);
        end
        @(negedge clk);
        compared++;
        if (cmd_ack !== 1'b0) begin
            mismatched++;
            $display("FAIL dur_ack_pulse: got %b, expected 0", cmd_ack);
        end
        push_ev(3'd2, e + 100);
        push_ev(3'd3, e + 130);
        push_ev(3'd4, e + 150);
        push_ev(3'd5, e + 250);
        push_ev(3'd0, e + 280);
        push_ev(3'd1, e + 300);
        push_ev(3'd2, e + 350);
        wait_until(e + 310);
        send(8'h0A, 1'b0);
        compared++;
        if (cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL restore_ack: got %b, expected 1", cmd_ack);
        end
        wait_until(e + 351);
        check_drained("duration");
        n = e + 550;
    endtask

    task automatic test_ped(input int n, output int f);
        int n2;
        push_ev(3'd3, n - 170);
        push_ev(3'd4, n - 150);
        push_ev(3'd5, n - 50);
        push_ev(3'd0, n - 20);
        push_ev(3'd1, n);
        push_ev(3'd2, n + 50);
        push_ev(3'd3, n + 80);
        push_ev(3'd4, n + 100);
        push_ev(3'd5, n + 200);
        push_ev(3'd0, n + 230);
        push_ev(3'd1, n + 250);
        wait_until(n + 20);
        send(8'hC0, 1'b0);
        compared++;
        if (cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL ped_ack: got %b, expected 1", cmd_ack);
        end
        n2 = n + 250;
        push_ev(3'd2, n2 + 100);
        wait_until(n2 + 85);
        send(8'hC0, 1'b0);
        compared++;
        if (cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL ped_late_ack: got %b, expected 1", cmd_ack);
        end
        wait_until(n2 + 101);
        check_drained("ped");
        f = n2 + 110;
    endtask

    task automatic test_flash(input int f);
        wait_until(f);
        push_ev(3'd6, f + 1);
        send(8'h80, 1'b0);
        compared++;
        if (phase !== 3'd6 || cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL flash_enter: got phase=%0d ack=%b, expected 6 1",
                     phase, cmd_ack);
        end
        compared++;
        if (ns_light !== 3'b010 || ew_light !== 3'b010) begin
            mismatched++;
            $display("FAIL flash_on: got ns=%b ew=%b, expected 010 010",
                     ns_light, ew_light);
        end
        wait_until(f + 10);
        compared++;
        if (ns_light !== 3'b010) begin
            mismatched++;
            $display("FAIL flash_hold: got %b, expected 010", ns_light);
        end
        wait_until(f + 11);
        compared++;
        if (ns_light !== 3'b000 || ew_light !== 3'b000) begin
            mismatched++;
            $display("FAIL flash_off: got ns=%b ew=%b, expected 000 000",
                     ns_light, ew_light);
        end
        wait_until(f + 21);
        compared++;
        if (ns_light !== 3'b010 || ew_light !== 3'b010) begin
            mismatched++;
            $display("FAIL flash_again: got ns=%b ew=%b, expected 010 010",
                     ns_light, ew_light);
        end
    endtask

    task automatic test_flash_exit(input int x);
        wait_until(x);
        push_ev(3'd0, x + 1);
        push_ev(3'd1, x + 21);
        send(8'hA0, 1'b0);
        compared++;
        if (ns_light !== 3'b100 || ew_light !== 3'b100 || cmd_ack !== 1'b1) begin
            mismatched++;
            $display("FAIL flash_exit: got ns=%b ew=%b ack=%b, expected 100 100 1",
                     ns_light, ew_light, cmd_ack);
        end
    endtask

    task automatic test_errors(input int x);
        logic [7:0] bad[3];
        logic       berr[3];
        bad  = '{8'h20, 8'hE5, 8'h01};
        berr = '{1'b0, 1'b0, 1'b1};
        wait_until(x + 30);
        for (int i = 0; i < 3; i++) begin
            send(bad[i], berr[i]);
            compared++;
            if (cmd_ack !== 1'b0 || led_error !== 1'b1) begin
                mismatched++;
                $display("FAIL reject_%0d: got ack=%b err=%b, expected 0 1",
                         i, cmd_ack, led_error);
            end
        end
        push_ev(3'd2, x + 121);
        push_ev(3'd3, x + 151);
        push_ev(3'd4, x + 171);
        push_ev(3'd5, x + 271);
        push_ev(3'd0, x + 301);
        push_ev(3'd1, x + 321);
        push_ev(3'd2, x + 421);
        wait_until(x + 330);
        send(8'hA0, 1'b0);
        compared++;
        if (cmd_ack !== 1'b1 || led_error !== 1'b0) begin
            mismatched++;
            $display("FAIL error_clear: got ack=%b err=%b, expected 1 0",
                     cmd_ack, led_error);
        end
        wait_until(x + 422);
        check_drained("errors");
    endtask

    task automatic test_reset_mid(input int x);
        push_ev(3'd3, x + 451);
        push_ev(3'd4, x + 471);
        wait_until(x + 490);
        send(8'hE5, 1'b0);
        wait_until(x + 499);
        send(8'h45, 1'b0);
        compared++;
        if (phase !== 3'd4 || cmd_ack !== 1'b1 || led_error !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset: got phase=%0d ack=%b err=%b, expected 4 1 1",
                     phase, cmd_ack, led_error);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (ns_light !== 3'b100 || ew_light !== 3'b100 || phase !== 3'd0 ||
            cmd_ack !== 1'b0 || led_error !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: got ns=%b ew=%b ph=%0d ack=%b err=%b, expected 100 100 0 0 0",
                     ns_light, ew_light, phase, cmd_ack, led_error);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_drained("reset_mid");
    endtask

    initial begin
        int r;
        int n;
        int f;
        int x;
        test_reset(r);
        test_normal_cycle(r);
        test_duration_write(r + 320, n);
        test_ped(n, f);
        test_flash(f);
        x = f + 25;
        test_flash_exit(x);
        test_errors(x);
        test_reset_mid(x);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
